// File: rtl/hcsr04_medidor_pkg.sv
// Shared definitions for the HC-SR04 measurement stage: FSM state codes,
// BCD geometry and the saturating 3-digit BCD increment.
package hcsr04_medidor_pkg;

    localparam int BCD_DIGITO_W = 4;
    localparam int BCD_DIGITOS  = 3;
    localparam int BCD_W        = BCD_DIGITO_W * BCD_DIGITOS;
    localparam logic [BCD_W-1:0] BCD_SATURADO = 12'h999;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        ENVIA_TRIGGER = 4'h2,
        ESPERA_ECHO   = 4'h3,
        MEDE          = 4'h4,
        ARMAZENA      = 4'h5,
        FINAL         = 4'h6,
        ERRO          = 4'hF
    } estado_t;

    // Adds one with decimal carry across digits; 999 is sticky.
    function automatic logic [BCD_W-1:0] bcd_incrementa(input logic [BCD_W-1:0] valor);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = valor;
        carry = (valor != BCD_SATURADO);
        for (int d = 0; d < BCD_DIGITOS; d++) begin
            if (carry) begin
                if (r[d*BCD_DIGITO_W +: BCD_DIGITO_W] == 4'd9) begin
                    r[d*BCD_DIGITO_W +: BCD_DIGITO_W] = 4'd0;
                end else begin
                    r[d*BCD_DIGITO_W +: BCD_DIGITO_W] = r[d*BCD_DIGITO_W +: BCD_DIGITO_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hcsr04_medidor_if.sv
// Signal bundle between the range finder's control/datapath and the measurement stage.
interface hcsr04_medidor_if;
    import hcsr04_medidor_pkg::*;

    logic             medir;
    logic             echo;
    logic             trigger;
    logic [BCD_W-1:0] medida;
    logic             pronto;
    logic             erro;
    logic [3:0]       db_estado;

    modport master (
        output medir, echo,
        input  trigger, medida, pronto, erro, db_estado
    );

    modport slave (
        input  medir, echo,
        output trigger, medida, pronto, erro, db_estado
    );

endinterface

// File: rtl/hcsr04_medidor_contador_bcd_3digitos.sv
// Three-digit BCD centimetre counter: synchronous clear, increment enable,
// saturates at 999. Also exposes the value it would take on the next increment.
module contador_bcd_3digitos
    import hcsr04_medidor_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             limpa,
    input  logic             incrementa,
    output logic [BCD_W-1:0] valor,
    output logic [BCD_W-1:0] proximo
);

    assign proximo = bcd_incrementa(valor);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (limpa) begin
            valor <= '0;
        end else if (incrementa) begin
            valor <= proximo;
        end
    end

endmodule

// File: rtl/hcsr04_medidor.sv
// HC-SR04 measurement stage: fires the trigger on medir, times the echo pulse and
// reports its width in centimetres as 3-digit BCD, with timeouts on both echo edges.
module hcsr04_medidor
    import hcsr04_medidor_pkg::*;
#(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic             clock,
    input  logic             reset,
    hcsr04_medidor_if.slave  bus
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIGGER_CYCLES) ? TIMEOUT_CYCLES : TRIGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TICK_W  = $clog2(CYCLES_PER_CM + 1);

    localparam logic [CNT_W-1:0]  TRIG_FIM    = CNT_W'(TRIGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_FIM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_FIM    = TICK_W'(CYCLES_PER_CM - 1);
    localparam logic [TICK_W-1:0] TICK_METADE = TICK_W'(CYCLES_PER_CM / 2);

    estado_t          estado;
    logic [CNT_W-1:0] contador;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] tick_prox;
    logic             echo_meta;
    logic             echo_s;
    logic             conta_tick;
    logic             arredonda;
    logic             trigger_q;
    logic             pronto_q;
    logic             erro_q;
    logic [BCD_W-1:0] medida_q;
    logic [BCD_W-1:0] bcd_valor;
    logic [BCD_W-1:0] bcd_proximo;

    // Two-flop synchroniser; the same delay hits both edges, so width is preserved.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
        end else begin
            echo_meta <= bus.echo;
            echo_s    <= echo_meta;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        conta_tick = 1'b0;
        tick_prox  = tick + TICK_W'(1);
        arredonda  = (tick >= TICK_METADE);
        if (tick == TICK_FIM) begin
            tick_prox = '0;
        end
        // The rise cycle itself is counted, so ESPERA_ECHO contributes one tick.
        if (echo_s && ((estado == ESPERA_ECHO) ||
                       (estado == MEDE && contador != TIMEOUT_FIM))) begin
            conta_tick = 1'b1;
        end
    end

    contador_bcd_3digitos u_bcd (
        .clock      (clock),
        .reset      (reset),
        .limpa      (estado == PREPARA),
        .incrementa (conta_tick && (tick == TICK_FIM)),
        .valor      (bcd_valor),
        .proximo    (bcd_proximo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            contador  <= '0;
            tick      <= '0;
            trigger_q <= 1'b0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
            medida_q  <= '0;
        end else begin
            pronto_q <= 1'b0;
            if (conta_tick) begin
                tick <= tick_prox;
            end
            case (estado)
                INICIAL: begin
                    if (bus.medir) begin
                        estado <= PREPARA;
                    end
                end
                PREPARA: begin
                    contador  <= '0;
                    tick      <= '0;
                    erro_q    <= 1'b0;
                    trigger_q <= 1'b1;
                    estado    <= ENVIA_TRIGGER;
                end
                ENVIA_TRIGGER: begin
                    if (contador == TRIG_FIM) begin
                        trigger_q <= 1'b0;
                        contador  <= '0;
                        estado    <= ESPERA_ECHO;
                    end else begin
                        contador <= contador + CNT_W'(1);
                    end
                end
                ESPERA_ECHO: begin
                    if (echo_s) begin
                        contador <= CNT_W'(1);
                        estado   <= MEDE;
                    end else if (contador == TIMEOUT_FIM) begin
                        pronto_q <= 1'b1;
                        erro_q   <= 1'b1;
                        estado   <= ERRO;
                    end else begin
                        contador <= contador + CNT_W'(1);
                    end
                end
                MEDE: begin
                    if (!echo_s) begin
                        estado <= ARMAZENA;
                    end else if (contador == TIMEOUT_FIM) begin
                        pronto_q <= 1'b1;
                        erro_q   <= 1'b1;
                        estado   <= ERRO;
                    end else begin
                        contador <= contador + CNT_W'(1);
                    end
                end
                ARMAZENA: begin
                    medida_q <= arredonda ? bcd_proximo : bcd_valor;
                    pronto_q <= 1'b1;
                    estado   <= FINAL;
                end
                FINAL:   estado <= INICIAL;
                ERRO:    estado <= INICIAL;
                default: estado <= INICIAL;
            endcase
        end
    end

    assign bus.trigger   = trigger_q;
    assign bus.pronto    = pronto_q;
    assign bus.erro      = erro_q;
    assign bus.medida    = medida_q;
    assign bus.db_estado = estado;

endmodule
